// File: rtl/adder64_result_stage.sv
// Result stage behind the pipelined 64-bit SIMD adder: captures sums, derives per-lane
// N/Z/C/V flags and buffers results in a credit-managed show-ahead FIFO.
module adder64_result_stage #(
    parameter int LEN_DATA = 64,
    parameter int LATENCY  = 9,
    parameter int TAG_W    = 4,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [TAG_W-1:0]    issue_tag,
    input  logic [1:0]          issue_lsz,
    input  logic [7:0]          issue_a_msb,
    input  logic [7:0]          issue_b_msb,
    output logic                issue_ready,
    input  logic [LEN_DATA-1:0] add_sum,
    input  logic                add_cout,
    input  logic                add_rdy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_DATA-1:0] out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic [7:0]          out_n,
    output logic [7:0]          out_z,
    output logic [7:0]          out_c,
    output logic [7:0]          out_v,
    output logic                out_err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [1:0]       lsz;
        logic [7:0]       a_msb;
        logic [7:0]       b_msb;
    } sideband_t;

    typedef struct packed {
        logic [LEN_DATA-1:0] data;
        logic [TAG_W-1:0]    tag;
        logic [7:0]          n;
        logic [7:0]          z;
        logic [7:0]          c;
        logic [7:0]          v;
    } entry_t;

    sideband_t        sb [LATENCY];
    sideband_t        sb_last;
    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] fifo_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             accept;
    logic             pop;
    logic             capture;
    logic             fifo_full;
    logic             do_write;
    logic             cout_bad;
    logic [7:0]       top_mask;
    logic [7:0]       byte_zero;
    logic [7:0]       lane_zero;
    logic [7:0]       sum_msb;
    logic [7:0]       carry_in;
    logic [7:0]       carry;
    logic [7:0]       ovf;

    assign issue_ready = (cnt < CNT_MAX);
    assign accept      = issue_valid & issue_ready;
    assign out_valid   = (fifo_cnt != '0);
    assign pop         = out_valid & out_ready;
    assign sb_last     = sb[LATENCY-1];
    assign capture     = add_rdy & sb_last.valid;
    assign fifo_full   = (fifo_cnt == CNT_MAX);
    assign do_write    = capture & ~fifo_full;

    // Credit covers both ops in the adder pipe and results still in the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + 1'b1;
        end else if (pop && !accept) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= {accept, issue_tag, issue_lsz, issue_a_msb, issue_b_msb};
            for (int i = 1; i < LATENCY; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    // Carry into each byte's top bit is recovered from s^a^b, giving C and V per lane top.
    always_comb begin
        case (sb_last.lsz)
            2'b00:   top_mask = 8'hFF;
            2'b01:   top_mask = 8'hAA;
            2'b10:   top_mask = 8'h88;
            default: top_mask = 8'h80;
        endcase
        for (int k = 0; k < 8; k++) begin
            byte_zero[k] = (add_sum[8*k +: 8] == 8'h00);
            sum_msb[k]   = add_sum[8*k+7];
        end
        for (int k = 0; k < 8; k++) begin
            case (sb_last.lsz)
                2'b00:   lane_zero[k] = byte_zero[k];
                2'b01:   lane_zero[k] = &byte_zero[(k/2)*2 +: 2];
                2'b10:   lane_zero[k] = &byte_zero[(k/4)*4 +: 4];
                default: lane_zero[k] = &byte_zero;
            endcase
        end
        carry_in      = sum_msb ^ sb_last.a_msb ^ sb_last.b_msb;
        carry         = (sb_last.a_msb & sb_last.b_msb) | ((sb_last.a_msb | sb_last.b_msb) & carry_in);
        ovf           = carry_in ^ carry;
        wr_entry.data = add_sum;
        wr_entry.tag  = sb_last.tag;
        wr_entry.n    = sum_msb & top_mask;
        wr_entry.z    = lane_zero & top_mask;
        wr_entry.c    = carry & top_mask;
        wr_entry.v    = ovf & top_mask;
        cout_bad      = capture & (carry[7] != add_cout);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_err <= 1'b0;
        end else if ((add_rdy != sb_last.valid) || cout_bad || (capture && fifo_full)) begin
            out_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            if (do_write && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !do_write) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Storage is not reset, so the head is masked to read zero whenever the FIFO is empty.
    always_comb begin
        head = out_valid ? mem[rd_ptr] : '0;
    end

    assign out_data = head.data;
    assign out_tag  = head.tag;
    assign out_n    = head.n;
    assign out_z    = head.z;
    assign out_c    = head.c;
    assign out_v    = head.v;

endmodule
